// File: rtl/pipe_bank.sv
// pipe_bank: multi-channel scrolling obstacle pipes with run/halt control,
// selectable scroll speed, pseudo-random gap respawn and saturating score.
module pipe_bank #(
    parameter int          NUM_PIPES     = 3,
    parameter int          X_W           = 11,
    parameter int          Y_W           = 10,
    parameter int          INIT_X        = 640,
    parameter int          SPACING       = 256,
    parameter int          BASE_STEP     = 2,
    parameter int          BIRD_X        = 200,
    parameter int          GAP_MIN       = 100,
    parameter int          GAP_SPAN_LOG2 = 8,
    parameter int          INIT_GAP      = 240,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     initalize,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     collide,
    input  logic [1:0]               speed_sel,
    output logic [NUM_PIPES*X_W-1:0] pipe_x_bus,
    output logic [NUM_PIPES*Y_W-1:0] pipe_y_bus,
    output logic                     running,
    output logic                     score_pulse,
    output logic [7:0]               score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam int TOTAL = NUM_PIPES * SPACING;

    if (INIT_X + TOTAL >= (1 << X_W)) begin : g_chk_x
        $error("pipe_bank: INIT_X + NUM_PIPES*SPACING overflows X_W");
    end
    if (GAP_MIN + (1 << GAP_SPAN_LOG2) - 1 >= (1 << Y_W)) begin : g_chk_y
        $error("pipe_bank: gap range overflows Y_W");
    end
    if (NUM_PIPES < 1 || NUM_PIPES > 4) begin : g_chk_n
        $error("pipe_bank: NUM_PIPES must be 1..4");
    end

    logic [1:0]           r_state;
    logic [15:0]          r_lfsr;
    logic [X_W-1:0]       r_x [NUM_PIPES];
    logic [Y_W-1:0]       r_y [NUM_PIPES];
    logic [7:0]           r_score;
    logic                 r_pulse;
    logic                 r_running;

    logic [X_W-1:0]           w_step;
    logic [X_W-1:0]           w_x_nxt [NUM_PIPES];
    logic [Y_W-1:0]           w_y_nxt [NUM_PIPES];
    logic                     w_wrap  [NUM_PIPES];
    logic [GAP_SPAN_LOG2-1:0] w_rnd   [NUM_PIPES];
    logic [2:0]               w_cnt;
    logic [8:0]               w_sum;
    logic [7:0]               w_score_nxt;
    logic                     w_move;
    logic                     w_restart;
    logic                     w_fb;

    // Step size, per-pipe next position/gap and pass count for this tick
    always_comb begin
        w_step = X_W'(BASE_STEP * (int'(speed_sel) + 1));
        w_cnt  = 3'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_wrap[i] = (r_x[i] < w_step);
            if (w_wrap[i]) begin
                w_x_nxt[i] = r_x[i] + X_W'(TOTAL) - w_step;
            end else begin
                w_x_nxt[i] = r_x[i] - w_step;
            end
            for (int b = 0; b < GAP_SPAN_LOG2; b++) begin
                w_rnd[i][b] = r_lfsr[(b + 16 - ((2 * i) % 16)) % 16];
            end
            w_y_nxt[i] = Y_W'(GAP_MIN) + Y_W'(w_rnd[i]);
            if (!w_wrap[i] && (r_x[i] >= X_W'(BIRD_X))
                && (w_x_nxt[i] < X_W'(BIRD_X))) begin
                w_cnt = w_cnt + 3'd1;
            end
        end
        w_sum = 9'(r_score) + 9'(w_cnt);
        w_score_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
    end

    assign w_move = (r_state == S_RUN) && tick && !collide;
    assign w_restart = start && (r_state != S_RUN);
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running gap randomiser, never reseeded on restart
    always_ff @(posedge clk or posedge initalize) begin
        if (initalize) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Run/halt control, pipe motion and scoring
    always_ff @(posedge clk or posedge initalize) begin
        if (initalize) begin
            r_state   <= S_IDLE;
            r_score   <= 8'd0;
            r_pulse   <= 1'b0;
            r_running <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_x[i] <= X_W'(INIT_X + i * SPACING);
                r_y[i] <= Y_W'(INIT_GAP);
            end
        end else begin
            r_pulse <= 1'b0;
            if (w_restart) begin
                r_state   <= S_RUN;
                r_running <= 1'b1;
                r_score   <= 8'd0;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    r_x[i] <= X_W'(INIT_X + i * SPACING);
                    r_y[i] <= Y_W'(INIT_GAP);
                end
            end else if ((r_state == S_RUN) && collide) begin
                r_state   <= S_HALT;
                r_running <= 1'b0;
            end else if (w_move) begin
                r_score <= w_score_nxt;
                r_pulse <= (w_cnt != 3'd0);
                for (int i = 0; i < NUM_PIPES; i++) begin
                    r_x[i] <= w_x_nxt[i];
                    if (w_wrap[i]) begin
                        r_y[i] <= w_y_nxt[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_bus
        assign pipe_x_bus[g*X_W +: X_W] = r_x[g];
        assign pipe_y_bus[g*Y_W +: Y_W] = r_y[g];
    end

    assign running     = r_running;
    assign score_pulse = r_pulse;
    assign score       = r_score;

endmodule

// File: doc/pipe_bank.md
Name: pipe_bank

Overview:
- Multi-channel successor to the single-pipe mover: holds NUM_PIPES obstacle pipes, scrolls them left in lock-step on an external frame tick, and respawns each pipe off the right edge with a pseudo-random gap height.
- Adds a run/halt state machine, selectable scroll speed, and scoring when a pipe passes the bird column.
- Sits between the game controller (tick, start, collide) and the VGA renderer, which reads the flattened position buses.

Parameters:
- NUM_PIPES, 3, number of pipe channels (1..4).
- X_W, 11, pipe x width in bits.
- Y_W, 10, gap y width in bits.
- INIT_X, 640, reset/restart x of pipe 0.
- SPACING, 256, horizontal distance between consecutive pipes.
- BASE_STEP, 2, pixels moved per tick at speed_sel=0.
- BIRD_X, 200, column used for score detection.
- GAP_MIN, 100, lowest gap y.
- GAP_SPAN_LOG2, 8, random gap span is 2^GAP_SPAN_LOG2 (gap in GAP_MIN..GAP_MIN+2^N-1).
- INIT_GAP, 240, gap y of every pipe after reset/restart.
- LFSR_SEED, 16'hACE1, nonzero LFSR seed.

Ports:
- clk  input  1  system clock.
- initalize  input  1  asynchronous active-high reset.
- tick  input  1  one-cycle scroll strobe (one per frame).
- start  input  1  one-cycle start/restart request.
- collide  input  1  one-cycle collision report.
- speed_sel  input  2  speed select; step = BASE_STEP*(speed_sel+1).
- pipe_x_bus  output  NUM_PIPES*X_W  pipe i left-edge x at bits [i*X_W +: X_W].
- pipe_y_bus  output  NUM_PIPES*Y_W  pipe i gap y at bits [i*Y_W +: Y_W].
- running  output  1  high in RUN.
- score_pulse  output  1  one-cycle pulse per pipe passing BIRD_X.
- score  output  8  saturating pass count.

Behaviour:
- Reset (initalize high, async, no clock required): state=IDLE; x_i=INIT_X+i*SPACING; y_i=INIT_GAP; lfsr=LFSR_SEED; score=0; score_pulse=0; running=0. Holds while asserted.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock in every state except reset.
- FSM states:
  - IDLE: no motion. start -> RUN with positions, gaps and score reinitialised to reset values (lfsr not reseeded).
  - RUN: on tick, move all pipes. collide -> HALT. start in RUN is ignored.
  - HALT: frozen, ticks ignored. start -> RUN with the same reinit as from IDLE.
- collide and tick in the same RUN cycle: collide wins; no movement, no score.
- Step: step = BASE_STEP*(speed_sel+1), sampled in the tick cycle. All outputs are registered, updated on the clock edge of the tick cycle (1-cycle latency).
- Per pipe on tick:
  - If x_i >= step: x_i <= x_i - step.
  - Else (wrap): x_i <= x_i + NUM_PIPES*SPACING - step. This preserves spacing exactly.
  - On wrap: y_i <= GAP_MIN + rot(lfsr, 2*i)[GAP_SPAN_LOG2-1:0], where rot is rotate-left. This gives distinct values when several pipes wrap in the same tick.
  - Non-wrapping pipes keep y_i.
- Score: a pipe passes when it does not wrap and x_old >= BIRD_X and x_new < BIRD_X.
  - score_pulse is high for exactly one cycle after the tick if one or more pipes pass.
  - score increments by the number of passing pipes, saturating at 255.
  - score_pulse still fires at saturation.
- Widths: INIT_X + NUM_PIPES*SPACING must be < 2^X_W, and GAP_MIN + 2^GAP_SPAN_LOG2 - 1 must be < 2^Y_W. Check both with elaboration-time assertions.

Test Plan:
- Reset: assert initalize mid-RUN between clock edges -> outputs immediately show x=640/896/1152, y=240 each, score=0, running=0.
- Speed: start, speed_sel=0, one tick -> x=638/894/1150. speed_sel=3, one tick -> x=630/886/1142.
- Score: drive pipe0 to x=202, speed 0, tick -> x=200, no pulse. Tick again -> x=198, score_pulse for one cycle, score=1.
- Wrap: pipe0 at x=1, step 2 -> x=767. New y in 100..355 and equal to GAP_MIN + lfsr[7:0] sampled in the tick cycle. Other pipes' y unchanged.
- Collide: collide and tick in the same cycle -> positions unchanged, running=0. Further ticks do nothing. start -> RUN, reset positions, score=0.
- Saturation: force 300 passes -> score stays 255 and score_pulse still toggles on each pass.
